// File: rtl/lmi_icache_fill_pkg.sv
// Shared symbols for the I-side line-fill engine: one-hot state indices,
// the default last-beat counter value and the word-offset field position.
package lmi_icache_fill_pkg;

  localparam int unsigned IFL_ST_IDLE = 0;
  localparam int unsigned IFL_ST_REQ  = 1;
  localparam int unsigned IFL_ST_DATA = 2;
  localparam int unsigned IFL_ST_DONE = 3;
  localparam int unsigned IFL_ST_LAST = 3;
  localparam int unsigned IFL_ST_W    = IFL_ST_LAST + 1;

  typedef logic [IFL_ST_W-1:0] ifl_state_t;

  localparam ifl_state_t IFL_IDLE_OH = ifl_state_t'(1) << IFL_ST_IDLE;
  localparam ifl_state_t IFL_REQ_OH  = ifl_state_t'(1) << IFL_ST_REQ;
  localparam ifl_state_t IFL_DATA_OH = ifl_state_t'(1) << IFL_ST_DATA;
  localparam ifl_state_t IFL_DONE_OH = ifl_state_t'(1) << IFL_ST_DONE;

  // Beat index the I-cache control SM waits for (4-word line)
  localparam int unsigned LINE_CTR_LAST = 3;

  // Word offset within a line sits just above the byte-lane bits
  localparam int unsigned IFL_WOFF_LSB = 2;

endpackage

// File: rtl/lmi_ifill_ctr.sv
// Beat counter for the fill engine plus the line-wrapped word-offset adder.
module lmi_ifill_ctr #(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CTR_W-1:0] start_off_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] ctr_o,
  output logic [CTR_W-1:0] woff_c_o
);

  logic [CTR_W-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (clr_i) begin
      ctr_d = '0;
    end else if (inc_i) begin
      ctr_d = ctr_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;
  // Truncation to CTR_W bits gives the wrap within the line
  assign woff_c_o = start_off_i + ctr_q;

endmodule

// File: rtl/lmi_icache_fill.sv
// I-side line-fill / uncached-fetch burst engine between the I-cache control SM
// and the external bus. Define LMI_IFILL_CWF_EN for critical-word-first fills.
module lmi_icache_fill
  import lmi_icache_fill_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CTR_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fill_req_i,
  input  logic              uncached_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_burst_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rdy_i,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_err_i,
  output logic              is_val_o,
  output logic [DATA_W-1:0] is_data_o,
  output logic [CTR_W-1:0]  is_woff_o,
  output logic [CTR_W-1:0]  burst_ctr_o,
  output logic              fill_done_o,
  output logic              fill_err_o,
  output logic              other_busy_o
);

  localparam logic [CTR_W-1:0]  CTR_LAST  = CTR_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'((1 << IFL_WOFF_LSB) - 1);

  ifl_state_t state_q, state_d;

  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_burst_q, bus_burst_d;
  logic              is_val_q, is_val_d;
  logic [DATA_W-1:0] is_data_q, is_data_d;
  logic [CTR_W-1:0]  is_woff_q, is_woff_d;
  logic [CTR_W-1:0]  burst_ctr_q, burst_ctr_d;
  logic              fill_done_q, fill_done_d;
  logic              fill_err_q, fill_err_d;
  logic              other_busy_q, other_busy_d;
  logic              err_q, err_d;

  logic              accept_c, beat_c, last_c;
  logic              ctr_clr_c, ctr_inc_c;
  logic [CTR_W-1:0]  beat_idx, woff_c, start_off;
  logic [ADDR_W-1:0] addr_mask_c;

`ifdef LMI_IFILL_CWF_EN
  localparam int unsigned WOFF_MSB = IFL_WOFF_LSB + CTR_W - 1;
  logic [CTR_W-1:0] start_off_q, start_off_d;

  // Burst starts at the missed word; the bus wraps within the line
  assign addr_mask_c = WORD_MASK;
  assign start_off   = start_off_q;

  always_comb begin
    start_off_d = start_off_q;
    if (accept_c) start_off_d = req_addr_i[WOFF_MSB:IFL_WOFF_LSB];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) start_off_q <= '0;
    else         start_off_q <= start_off_d;
  end
`else
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((LINE_WORDS << IFL_WOFF_LSB) - 1);

  assign addr_mask_c = uncached_i ? WORD_MASK : LINE_MASK;
  assign start_off   = '0;
`endif

  assign accept_c = state_q[IFL_ST_IDLE] & fill_req_i;
  assign beat_c   = state_q[IFL_ST_DATA] & bus_rdy_i;
  assign last_c   = !bus_burst_q || (beat_idx == CTR_LAST);

  lmi_ifill_ctr #(.CTR_W(CTR_W)) u_ctr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_off_i (start_off),
    .clr_i       (ctr_clr_c),
    .inc_i       (ctr_inc_c),
    .ctr_o       (beat_idx),
    .woff_c_o    (woff_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IFL_IDLE_OH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q[IFL_ST_IDLE]) begin
      if (fill_req_i) state_d = IFL_REQ_OH;
    end else if (state_q[IFL_ST_REQ]) begin
      if (bus_gnt_i) state_d = IFL_DATA_OH;
    end else if (state_q[IFL_ST_DATA]) begin
      if (beat_c && last_c) state_d = IFL_DONE_OH;
    end else begin
      // DONE, or any non-one-hot encoding, returns to IDLE
      state_d = IFL_IDLE_OH;
    end
  end

  always_comb begin
    bus_req_d    = bus_req_q;
    bus_addr_d   = bus_addr_q;
    bus_burst_d  = bus_burst_q;
    is_val_d     = 1'b0;
    is_data_d    = is_data_q;
    is_woff_d    = is_woff_q;
    burst_ctr_d  = burst_ctr_q;
    fill_done_d  = 1'b0;
    fill_err_d   = 1'b0;
    other_busy_d = other_busy_q;
    err_d        = err_q;
    ctr_clr_c    = 1'b0;
    ctr_inc_c    = 1'b0;

    // Busy stays up through the FILL_DONE cycle and drops in the next IDLE cycle
    if (state_q[IFL_ST_IDLE]) other_busy_d = fill_req_i;
    if (accept_c) begin
      bus_req_d   = 1'b1;
      bus_addr_d  = req_addr_i & ~addr_mask_c;
      bus_burst_d = !uncached_i;
      err_d       = 1'b0;
      ctr_clr_c   = 1'b1;
    end
    if (state_q[IFL_ST_REQ] && bus_gnt_i) bus_req_d = 1'b0;
    if (beat_c) begin
      is_val_d    = 1'b1;
      is_data_d   = bus_data_i;
      is_woff_d   = woff_c;
      burst_ctr_d = beat_idx;
      err_d       = err_q | bus_err_i;
      ctr_inc_c   = 1'b1;
    end
    if (state_q[IFL_ST_DONE]) begin
      fill_done_d = 1'b1;
      fill_err_d  = err_q;
      err_d       = 1'b0;
      burst_ctr_d = '0;
      ctr_clr_c   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_req_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_burst_q  <= 1'b0;
      is_val_q     <= 1'b0;
      is_data_q    <= '0;
      is_woff_q    <= '0;
      burst_ctr_q  <= '0;
      fill_done_q  <= 1'b0;
      fill_err_q   <= 1'b0;
      other_busy_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bus_req_q    <= bus_req_d;
      bus_addr_q   <= bus_addr_d;
      bus_burst_q  <= bus_burst_d;
      is_val_q     <= is_val_d;
      is_data_q    <= is_data_d;
      is_woff_q    <= is_woff_d;
      burst_ctr_q  <= burst_ctr_d;
      fill_done_q  <= fill_done_d;
      fill_err_q   <= fill_err_d;
      other_busy_q <= other_busy_d;
      err_q        <= err_d;
    end
  end

  assign bus_req_o    = bus_req_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_burst_o  = bus_burst_q;
  assign is_val_o     = is_val_q;
  assign is_data_o    = is_data_q;
  assign is_woff_o    = is_woff_q;
  assign burst_ctr_o  = burst_ctr_q;
  assign fill_done_o  = fill_done_q;
  assign fill_err_o   = fill_err_q;
  assign other_busy_o = other_busy_q;

endmodule
